// File: rtl/ext_loader_pkg.sv
// ext_loader_pkg: shared types and constants for the external loader.
//   state_t        - loader session FSM states
//   WORD_STRIDE    - byte distance between consecutive memory words
//   DEF_*_DEPTH    - default instruction/data memory depths (words)
//   sat_len()      - clamps a requested word count to a memory depth
package ext_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        FIN
    } state_t;

    localparam logic [31:0] WORD_STRIDE    = 32'd4;
    localparam int unsigned DEF_IMEM_DEPTH = 512;
    localparam int unsigned DEF_DMEM_DEPTH = 1024;

    function automatic logic [10:0] sat_len(input logic [10:0] len, input int unsigned depth);
        logic [10:0] d;
        d = depth[10:0];
        if (32'(len) > depth) return d;
        return len;
    endfunction

endpackage

// File: rtl/ext_loader_cnt.sv
// ext_loader_cnt: 32-bit run down-counter.
//   clk, arst   - clock, asynchronous active-high reset (clears count)
//   i_load      - load i_load_val (has priority over decrement)
//   i_load_val  - value to load
//   i_dec       - decrement by one; holds at zero, never wraps
//   o_zero      - count is zero
module ext_loader_cnt (
    input  logic        clk,
    input  logic        arst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_dec,
    output logic        o_zero
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ext_loader.sv
// ext_loader: sequences one load/run/dump session around a CPU.
//   clk, arst                 - clock, asynchronous active-high reset
//   start                     - begins a session (ignored while busy)
//   imem_len/dmem_len         - words to load into instruction/data memory
//   run_cycles                - cycles cpu_enable is held high
//   dump_len                  - data-memory words streamed back
//   s_valid/s_ready/s_data    - load-word stream in
//   m_valid/m_ready/m_data    - dump-word stream out
//   cpu_enable                - CPU enable
//   *_ext                     - instruction-memory external port
//   *_ext_2                   - data-memory external port
//   busy, done                - session in progress / one-cycle end pulse
module ext_loader
    import ext_loader_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [9:0]        imem_len,
    input  logic [10:0]       dmem_len,
    input  logic [31:0]       run_cycles,
    input  logic [10:0]       dump_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic [10:0]       r_idx;
    logic [10:0]       r_ilen;
    logic [10:0]       r_dlen;
    logic [10:0]       r_dump;
    logic              r_run_nz;
    logic [DATA_W-1:0] r_mdata;

    logic [10:0]       w_ilen;
    logic [10:0]       w_dlen;
    logic [10:0]       w_dump;
    logic              w_run_nz;
    logic [10:0]       w_idx_nxt;
    logic [31:0]       w_addr;
    logic              w_accept;
    logic              w_idx_clr;
    logic              w_idx_inc;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_cap;
    state_t            w_after_i;
    state_t            w_after_d;
    state_t            w_after_run;
    state_t            w_first;

    // Instruction-memory read data is never needed.
    logic w_unused;
    assign w_unused = ^rdata_ext;

    // In IDLE the lengths come straight from the (saturated) inputs so the
    // first phase can be chosen in the same cycle start is accepted.
    assign w_ilen   = (r_state == IDLE) ? sat_len({1'b0, imem_len}, IMEM_DEPTH) : r_ilen;
    assign w_dlen   = (r_state == IDLE) ? sat_len(dmem_len, DMEM_DEPTH) : r_dlen;
    assign w_dump   = (r_state == IDLE) ? sat_len(dump_len, DMEM_DEPTH) : r_dump;
    assign w_run_nz = (r_state == IDLE) ? (run_cycles != '0) : r_run_nz;

    // Phase skip chain: each entry is the first non-empty phase after it.
    assign w_after_run = (w_dump != '0) ? DUMP_RD : FIN;
    assign w_after_d   = w_run_nz ? RUN : w_after_run;
    assign w_after_i   = (w_dlen != '0) ? LOAD_D : w_after_d;
    assign w_first     = (w_ilen != '0) ? LOAD_I : w_after_i;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_idx_nxt = r_idx + 11'd1;
    assign w_addr    = 32'(r_idx) * WORD_STRIDE;
    assign m_data    = r_mdata;

    // Loaded with run_cycles-1 so that RUN exits on the zero flag after
    // exactly run_cycles cycles; the wrapped value for zero is never used.
    ext_loader_cnt u_cnt (
        .clk        (clk),
        .arst       (arst),
        .i_load     (w_accept),
        .i_load_val (run_cycles - 32'd1),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_idx    <= '0;
            r_ilen   <= '0;
            r_dlen   <= '0;
            r_dump   <= '0;
            r_run_nz <= 1'b0;
            r_mdata  <= '0;
        end else begin
            if (w_accept) begin
                r_ilen   <= w_ilen;
                r_dlen   <= w_dlen;
                r_dump   <= w_dump;
                r_run_nz <= w_run_nz;
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= w_idx_nxt;
            end
            if (w_cap) begin
                r_mdata <= rdata_ext_2;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        busy        = 1'b1;
        done        = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_idx_clr = 1'b1;
                    w_next    = w_first;
                end
            end
            LOAD_I: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wen_ext   = 1'b1;
                    wdata_ext = s_data;
                    addr_ext  = w_addr;
                    if (w_idx_nxt == r_ilen) begin
                        w_idx_clr = 1'b1;
                        w_next    = w_after_i;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            LOAD_D: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wen_ext_2   = 1'b1;
                    wdata_ext_2 = s_data;
                    addr_ext_2  = w_addr;
                    if (w_idx_nxt == r_dlen) begin
                        w_idx_clr = 1'b1;
                        w_next    = w_after_d;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            RUN: begin
                cpu_enable = 1'b1;
                if (w_cnt_zero) begin
                    w_next = w_after_run;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = w_addr;
                w_next     = DUMP_CAP;
            end
            DUMP_CAP: begin
                w_cap  = 1'b1;
                w_next = DUMP_OUT;
            end
            DUMP_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (w_idx_nxt == r_dump) begin
                        w_idx_clr = 1'b1;
                        w_next    = FIN;
                    end else begin
                        w_idx_inc = 1'b1;
                        w_next    = DUMP_RD;
                    end
                end
            end
            FIN: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ext_loader.sv
// tb_ext_loader: randomized self-checking bench for ext_loader.
// A session-level model predicts memory writes, run length and dump data.
module tb_ext_loader;

    localparam int unsigned IDEP = 8;
    localparam int unsigned DDEP = 16;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [9:0]  imem_len;
    logic [10:0] dmem_len;
    logic [31:0] run_cycles;
    logic [10:0] dump_len;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        cpu_enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;
    logic        busy, done;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] sram    [0:DDEP-1];
    logic [31:0] ref_mem [0:DDEP-1];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;

    always #5 clk = ~clk;

    assign rdata_ext = 32'hDEAD_BEEF;

    ext_loader #(.DATA_W(32), .IMEM_DEPTH(IDEP), .DMEM_DEPTH(DDEP)) dut (
        .clk(clk), .arst(arst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    // Data-memory SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (wen_ext_2) sram[addr_ext_2[5:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= sram[addr_ext_2[5:2]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic preset(input int a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a[3:0]; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_ctrl"}, {s_ready, m_valid, cpu_enable, wen_ext, ren_ext,
                                  wen_ext_2, ren_ext_2, busy, done}, 0);
        check_eq({tag, "_bus"}, addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2, 0);
        check_eq({tag, "_mdata"}, m_data, 0);
    endtask

    // Called at posedge+1; returns at posedge+1.
    // sv_mode: 0 random, 1 always, 2 toggling.  mr_mode: 0 random, 1 always, 2 stall 3 cycles.
    task automatic run_session(input int il, input int dl, input logic [31:0] rc, input int dpl,
                               input int sv_mode, input int mr_mode, input bit poke, input bit fixed);
        int ei, ed, ep, k, cyc, last_act, done_cyc, n_done, viol, cpu_n, cpu_rises, ren_n, streak;
        bit prev_cpu, prev_stall, poked;
        logic [31:0] prev_md;
        logic [31:0] words [32];
        logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], dump_q[$];
        ei = imin(il, IDEP); ed = imin(dl, DDEP); ep = imin(dpl, DDEP);
        for (int i = 0; i < 32; i++) words[i] = fixed ? 32'(32'h11 * (i + 1)) : $urandom;
        k = 0; cyc = 0; last_act = 0; done_cyc = -1; n_done = 0; viol = 0;
        cpu_n = 0; cpu_rises = 0; ren_n = 0; streak = 0;
        prev_cpu = 0; prev_stall = 0; poked = 0; prev_md = '0;
        start = 1'b1; imem_len = il[9:0]; dmem_len = dl[10:0]; run_cycles = rc; dump_len = dpl[10:0];
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        while (cyc < 3000 && n_done == 0) begin
            @(negedge clk);
            if (cyc > 0 && !done && !busy) viol++;
            if (done && busy) viol++;
            if (s_ready && cpu_enable) viol++;
            if (cpu_enable && (wen_ext | ren_ext | wen_ext_2 | ren_ext_2)) viol++;
            if (!wen_ext && !ren_ext && (addr_ext != 0 || wdata_ext != 0)) viol++;
            if (!wen_ext_2 && !ren_ext_2 && (addr_ext_2 != 0 || wdata_ext_2 != 0)) viol++;
            if ((wen_ext || wen_ext_2) && !(s_valid && s_ready)) viol++;
            if (wen_ext && wen_ext_2) viol++;
            if ((wen_ext_2 || ren_ext_2) && addr_ext_2 >= 4 * DDEP) viol++;
            if (prev_stall && (!m_valid || m_data != prev_md)) viol++;
            if (cyc > 0 && done) begin n_done++; done_cyc = cyc; end
            if (wen_ext) begin iw_a.push_back(addr_ext); iw_d.push_back(wdata_ext); last_act = cyc; end
            if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); last_act = cyc; end
            if (cpu_enable) begin cpu_n++; if (!prev_cpu) cpu_rises++; last_act = cyc; end
            prev_cpu = cpu_enable;
            if (ren_ext_2) ren_n++;
            if (m_valid && m_ready) begin dump_q.push_back(m_data); last_act = cyc; end
            prev_stall = m_valid && !m_ready;
            prev_md = m_data;
            streak = (m_valid && !m_ready) ? streak + 1 : 0;
            if (s_valid && s_ready) k++;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (poke && cpu_enable && !poked) begin start = 1'b1; poked = 1; end
            imem_len = 10'($urandom); dmem_len = 11'($urandom);
            run_cycles = $urandom; dump_len = 11'($urandom);
            case (sv_mode)
                1: s_valid = 1'b1;
                2: s_valid = (cyc % 2 == 1);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = (k < 32) ? words[k] : $urandom;
            case (mr_mode)
                1: m_ready = 1'b1;
                2: m_ready = (streak >= 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_after", {busy, done}, 0);
        // Model: loads land at consecutive word addresses in stream order.
        check_eq("imem_wr_n", iw_a.size(), ei);
        for (int i = 0; i < iw_a.size() && i < ei; i++) begin
            check_eq($sformatf("imem_a%0d", i), iw_a[i], 4 * i);
            check_eq($sformatf("imem_d%0d", i), iw_d[i], words[i]);
        end
        for (int i = 0; i < ed; i++) ref_mem[i] = words[ei + i];
        check_eq("dmem_wr_n", dw_a.size(), ed);
        for (int i = 0; i < dw_a.size() && i < ed; i++) begin
            check_eq($sformatf("dmem_a%0d", i), dw_a[i], 4 * i);
            check_eq($sformatf("dmem_d%0d", i), dw_d[i], words[ei + i]);
        end
        check_eq("cpu_cycles", cpu_n, rc);
        check_eq("cpu_bursts", cpu_rises, (rc != 0) ? 1 : 0);
        check_eq("ren_count", ren_n, ep);
        check_eq("dump_n", dump_q.size(), ep);
        for (int i = 0; i < dump_q.size() && i < ep; i++)
            check_eq($sformatf("dump_d%0d", i), dump_q[i], ref_mem[i]);
        check_eq("done_seen", n_done, 1);
        check_eq("done_cycle", done_cyc, last_act + 1);
        check_eq("protocol", viol, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int dn;
        arst = 1'b1; start = 1'b0; imem_len = '0; dmem_len = '0; run_cycles = '0; dump_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs_zero("reset");
        arst = 1'b0;
        for (int i = 0; i < int'(DDEP); i++) preset(i, $urandom);

        // Three-word instruction load, back-to-back beats.
        run_session(3, 0, 0, 0, 1, 1, 0, 1);
        // Toggling s_valid into data memory.
        run_session(0, 2, 0, 0, 2, 1, 0, 0);
        // Pure run phase.
        run_session(0, 0, 5, 0, 1, 1, 0, 0);
        // Dump with m_ready held off for three cycles per word.
        preset(0, 32'hA0);
        preset(1, 32'hA1);
        run_session(0, 0, 0, 2, 1, 2, 0, 0);
        // start during RUN is ignored.
        run_session(0, 0, 6, 0, 1, 1, 1, 0);
        // Empty session, then over-depth lengths.
        run_session(0, 0, 0, 0, 1, 1, 0, 0);
        run_session(20, 40, 3, 40, 0, 0, 0, 0);
        for (int t = 0; t < 10; t++)
            run_session($urandom_range(0, 10), $urandom_range(0, 20), $urandom_range(0, 8),
                        $urandom_range(0, 20), $urandom_range(0, 2), $urandom_range(0, 2), 1, 0);

        // Abort mid instruction load after one of four beats.
        start = 1'b1; imem_len = 10'd4; dmem_len = '0; run_cycles = '0; dump_len = '0;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 32'h55;
        @(posedge clk); #1;
        s_data = 32'h66;
        @(negedge clk);
        check_eq("pre_abort_wen", wen_ext, 1);
        #2 arst = 1'b1;
        #1 check_outs_zero("abort");
        dn = 0;
        repeat (3) begin @(negedge clk); dn += int'(done); end
        @(posedge clk); #1;
        arst = 1'b0; s_valid = 1'b0;
        repeat (5) begin @(negedge clk); dn += int'(done); end
        check_eq("abort_no_done", dn, 0);
        @(posedge clk); #1;
        run_session(1, 0, 0, 0, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
